// File: rtl/double_buffer_reader.sv
// rtl/double_buffer_reader.sv - fetches a frame from a double buffer and streams it out through a 2-entry FIFO
module double_buffer_reader #(
  parameter int DATA_WIDTH    = 10,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     newData,
  input  logic [ADDRESS_WIDTH-1:0] dataLength,
  output logic [ADDRESS_WIDTH-1:0] readPointer,
  input  logic [DATA_WIDTH-1:0]    bufferData,
  output logic [DATA_WIDTH-1:0]    outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     outFirst,
  output logic                     outLast,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     clearOverrun,
  output logic [15:0]              frameCount
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} stateT;

  localparam logic [ADDRESS_WIDTH-1:0] ONE = 1;

  stateT                    state, nextState;
  logic [ADDRESS_WIDTH-1:0] frameLength;
  logic                     inFlight, inFlightFirst, inFlightLast;
  logic [DATA_WIDTH+1:0]    fifoMem [2];
  logic [DATA_WIDTH+1:0]    headEntry;
  logic                     rdIdx, wrIdx;
  logic [1:0]               fifoCount;
  logic [1:0]               occAfter;
  logic                     accept, issue, lastIssue;

  assign busy      = (state != IDLE);
  assign outValid  = (fifoCount != 2'd0);
  assign headEntry = fifoMem[rdIdx];
  assign outData   = headEntry[DATA_WIDTH-1:0];
  assign outFirst  = outValid & headEntry[DATA_WIDTH+1];
  assign outLast   = outValid & headEntry[DATA_WIDTH];
  assign accept    = outValid & outReady;
  assign lastIssue = (readPointer == frameLength - ONE);

  // Occupancy counts the slot freed by this cycle's accept, so a read can be
  // issued every cycle while the consumer keeps up.
  assign occAfter  = fifoCount - {1'b0, accept} + {1'b0, inFlight};
  assign issue     = (state == FETCH) && !newData && (occAfter < 2'd2);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (newData) begin
      nextState = (dataLength != '0) ? FETCH : IDLE;
    end else begin
      case (state)
        FETCH:   if (issue && lastIssue) nextState = DRAIN;
        DRAIN:   if (accept && outLast)  nextState = IDLE;
        default: nextState = state;
      endcase
    end
  end

  // Address issue; a newData pulse discards whatever read is in flight.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      frameLength   <= '0;
      readPointer   <= '0;
      inFlight      <= 1'b0;
      inFlightFirst <= 1'b0;
      inFlightLast  <= 1'b0;
    end else if (newData) begin
      frameLength <= dataLength;
      readPointer <= '0;
      inFlight    <= 1'b0;
    end else if (issue) begin
      inFlight      <= 1'b1;
      inFlightFirst <= (readPointer == '0);
      inFlightLast  <= lastIssue;
      if (!lastIssue) readPointer <= readPointer + ONE;
    end else begin
      inFlight <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
      rdIdx      <= 1'b0;
      wrIdx      <= 1'b0;
      fifoCount  <= 2'd0;
    end else if (newData) begin
      rdIdx     <= 1'b0;
      wrIdx     <= 1'b0;
      fifoCount <= 2'd0;
    end else begin
      if (inFlight) begin
        fifoMem[wrIdx] <= {inFlightFirst, inFlightLast, bufferData};
        wrIdx          <= ~wrIdx;
      end
      if (accept) rdIdx <= ~rdIdx;
      fifoCount <= fifoCount + {1'b0, inFlight} - {1'b0, accept};
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      overrun    <= 1'b0;
      frameCount <= 16'd0;
    end else begin
      overrun <= (newData & busy) | (overrun & ~clearOverrun);
      if (accept && outLast) frameCount <= frameCount + 16'd1;
    end
  end

endmodule
